// File: rtl/core_ctrl_if.sv
// Command/status bundle between the run controller (master) and the core_ctrl sequencer (slave).
// Run configuration, OFIFO status in, instruction word and run status out.
interface core_ctrl_if #(
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 8
);
   logic               start;
   logic [addr_bw-1:0] w_base;
   logic [addr_bw-1:0] a_base;
   logic [addr_bw-1:0] p_base;
   logic [cnt_bw-1:0]  nij;
   logic [cnt_bw-1:0]  n_kij;
   logic               ofifo_valid;
   logic [34:0]        inst;
   logic               busy;
   logic               done;

   modport master (
      output start, w_base, a_base, p_base, nij, n_kij, ofifo_valid,
      input  inst, busy, done
   );

   modport slave (
      input  start, w_base, a_base, p_base, nij, n_kij, ofifo_valid,
      output inst, busy, done
   );
endinterface

// File: rtl/core_ctrl.sv
// Instruction sequencer for the corelet: per kernel loads weights, kernel, activations,
// executes, then drains the OFIFO into psum memory; pulses done after n_kij kernels.
module core_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 8
) (
   input  logic        clk,
   input  logic        reset,
   core_ctrl_if.slave  bus
);

   localparam int CW = cnt_bw + 1;
   // Memory enables/write-enables are active-low, so the quiet word has them all high.
   localparam logic [34:0] IDLE_WORD = (35'd1 << 32) | (35'd1 << 31) | (35'd1 << 19) | (35'd1 << 18);

   typedef enum logic [3:0] {
      S_IDLE, S_WLOAD, S_KLOAD, S_KDRAIN, S_ALOAD, S_EXEC, S_OREAD, S_NEXT, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [cnt_bw-1:0]  k_q, k_d;
   logic [addr_bw-1:0] w_base_q, w_base_d, a_base_q, a_base_d, p_base_q, p_base_d;
   logic [cnt_bw-1:0]  nij_q, nij_d, nkij_q, nkij_d;
   logic [34:0]        inst_q, inst_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [addr_bw-1:0] w_off, p_off;
   logic [CW-1:0]      nij_ext;

   assign nij_ext = {1'b0, nij_q};
   assign w_off   = addr_bw'(32'(k_q) * col);
   assign p_off   = addr_bw'(32'(k_q) * 32'(nij_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         k_q      <= '0;
         w_base_q <= '0;
         a_base_q <= '0;
         p_base_q <= '0;
         nij_q    <= '0;
         nkij_q   <= '0;
         inst_q   <= IDLE_WORD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         w_base_q <= w_base_d;
         a_base_q <= a_base_d;
         p_base_q <= p_base_d;
         nij_q    <= nij_d;
         nkij_q   <= nkij_d;
         inst_q   <= inst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      w_base_d = w_base_q;
      a_base_d = a_base_q;
      p_base_d = p_base_q;
      nij_d    = nij_q;
      nkij_d   = nkij_q;
      unique case (state_q)
         S_IDLE: begin
            // busy_q still covers the done cycle, so a held start cannot retrigger.
            if (bus.start && !busy_q) begin
               w_base_d = bus.w_base;
               a_base_d = bus.a_base;
               p_base_d = bus.p_base;
               nij_d    = bus.nij;
               nkij_d   = bus.n_kij;
               cnt_d    = '0;
               k_d      = '0;
               state_d  = (bus.nij == '0 || bus.n_kij == '0) ? S_DONE : S_WLOAD;
            end
         end
         S_WLOAD: begin
            if (cnt_q == CW'(col)) begin
               state_d = S_KLOAD;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_KLOAD: begin
            if (cnt_q == CW'(col - 1)) begin
               state_d = S_KDRAIN;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_KDRAIN: begin
            if (cnt_q == CW'(row + col - 1)) begin
               state_d = S_ALOAD;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_ALOAD: begin
            if (cnt_q == nij_ext) begin
               state_d = S_EXEC;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_EXEC: begin
            if (cnt_q == nij_ext - CW'(1)) begin
               state_d = S_OREAD;
               cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end
         S_OREAD: begin
            if (bus.ofifo_valid) begin
               if (cnt_q == nij_ext - CW'(1)) begin
                  state_d = S_NEXT;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            k_d     = k_q + 1'b1;
            state_d = (k_d == nkij_q) ? S_DONE : S_WLOAD;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The word for the current state/count is registered, so it appears one cycle later.
   always_comb begin
      inst_d = IDLE_WORD;
      busy_d = (state_q != S_IDLE);
      done_d = (state_q == S_DONE);
      unique case (state_q)
         S_WLOAD: begin
            if (cnt_q < CW'(col)) begin
               inst_d[19]           = 1'b0;
               inst_d[7 +: addr_bw] = w_base_q + w_off + addr_bw'(cnt_q);
            end
            if (cnt_q != '0) inst_d[2] = 1'b1;
         end
         S_KLOAD: begin
            inst_d[3] = 1'b1;
            inst_d[0] = 1'b1;
         end
         S_ALOAD: begin
            if (cnt_q < nij_ext) begin
               inst_d[19]           = 1'b0;
               inst_d[7 +: addr_bw] = a_base_q + addr_bw'(cnt_q);
            end
            if (cnt_q != '0) inst_d[2] = 1'b1;
         end
         S_EXEC: begin
            inst_d[3] = 1'b1;
            inst_d[1] = 1'b1;
         end
         S_OREAD: begin
            if (bus.ofifo_valid) begin
               inst_d[6]             = 1'b1;
               inst_d[32]            = 1'b0;
               inst_d[31]            = 1'b0;
               inst_d[20 +: addr_bw] = p_base_q + p_off + addr_bw'(cnt_q);
            end
         end
         default: inst_d = IDLE_WORD;
      endcase
   end

   assign bus.inst = inst_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: vector table plus random runs scored against an event-level model,
// with hand sequences for reset, start timing, empty runs and a held start.
module tb_core_ctrl;
   localparam int ROW = 8;
   localparam int COL = 8;
   localparam int AW  = 11;
   localparam int CB  = 8;
   localparam logic [34:0] IDLE_W = (35'd1 << 32) | (35'd1 << 31) | (35'd1 << 19) | (35'd1 << 18);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   core_ctrl_if #(.addr_bw(AW), .cnt_bw(CB)) bus ();
   core_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .cnt_bw(CB)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // OFIFO valid source: 0 = always 1, 1 = random, 2 = repeating 1,0,0,1,1,0,1
   int vmode = 0;
   int pat_idx = 0;
   logic vld_edge = 1'b0;
   always @(negedge clk) begin
      case (vmode)
         1: bus.ofifo_valid = 1'($urandom_range(0, 1));
         2: begin
            bus.ofifo_valid = (pat_idx == 1 || pat_idx == 2 || pat_idx == 5) ? 1'b0 : 1'b1;
            pat_idx = (pat_idx + 1) % 7;
         end
         default: bus.ofifo_valid = 1'b1;
      endcase
   end
   always @(posedge clk) vld_edge <= bus.ofifo_valid;

   // Observed events
   logic [AW-1:0] got_rd_q[$];
   logic [AW-1:0] got_wr_q[$];
   int got_gap_q[$];
   int kl_cnt, ex_cnt, l0w_cnt, done_cnt, viol, lag_err, gap;
   bit prev_rd, in_gap;

   always @(negedge clk) begin
      if (!reset) begin
         logic [34:0] w;
         bit rd, wp;
         w  = bus.inst;
         rd = !w[19];
         wp = !w[32] && !w[31];
         if (rd) got_rd_q.push_back(w[17:7]);
         if (wp) begin
            got_wr_q.push_back(w[30:20]);
            if (!vld_edge) viol++;
         end
         if (w[0]) kl_cnt++;
         if (w[1]) ex_cnt++;
         if (w[2]) l0w_cnt++;
         if (bus.done) done_cnt++;
         if (w[2] != prev_rd) lag_err++;
         prev_rd = rd;
         if ((w[2] && w[3]) || (rd && !w[32]) || (w[0] && w[1]) || w[34] || w[33] || w[5] || w[4]) viol++;
         if (rd && !w[18]) viol++;
         if (w[6] != wp) viol++;
         if (w[0]) begin
            gap = 0;
            in_gap = 1;
         end else if (in_gap) begin
            if (rd) begin
               got_gap_q.push_back(gap);
               in_gap = 0;
            end else gap++;
         end
      end
   end

   task automatic clear_mon();
      got_rd_q.delete();
      got_wr_q.delete();
      got_gap_q.delete();
      kl_cnt = 0; ex_cnt = 0; l0w_cnt = 0; done_cnt = 0; viol = 0; lag_err = 0;
      gap = 0; prev_rd = 0; in_gap = 0;
   endtask

   // Reference: what a run must produce, straight from the sequencing rules.
   logic [AW-1:0] exp_rd_q[$];
   logic [AW-1:0] exp_wr_q[$];
   int exp_kl, exp_ex, exp_l0w, exp_nk;

   task automatic build_model(input int nij, input int nkij, input int w, input int a, input int p);
      exp_rd_q.delete();
      exp_wr_q.delete();
      exp_nk = (nij == 0 || nkij == 0) ? 0 : nkij;
      for (int k = 0; k < exp_nk; k++) begin
         for (int i = 0; i < COL; i++) exp_rd_q.push_back(AW'((w + k * COL + i) % 2048));
         for (int j = 0; j < nij; j++) exp_rd_q.push_back(AW'((a + j) % 2048));
         for (int j = 0; j < nij; j++) exp_wr_q.push_back(AW'((p + k * nij + j) % 2048));
      end
      exp_kl  = COL * exp_nk;
      exp_ex  = nij * exp_nk;
      exp_l0w = (COL + nij) * exp_nk;
   endtask

   task automatic score(input string tag);
      int mism;
      chk({tag, "_nreads"}, got_rd_q.size(), exp_rd_q.size());
      mism = 0;
      for (int i = 0; i < got_rd_q.size() && i < exp_rd_q.size(); i++)
         if (got_rd_q[i] !== exp_rd_q[i]) mism++;
      chk({tag, "_read_addrs_bad"}, mism, 0);
      chk({tag, "_nwrites"}, got_wr_q.size(), exp_wr_q.size());
      mism = 0;
      for (int i = 0; i < got_wr_q.size() && i < exp_wr_q.size(); i++)
         if (got_wr_q[i] !== exp_wr_q[i]) mism++;
      chk({tag, "_write_addrs_bad"}, mism, 0);
      chk({tag, "_kload"}, kl_cnt, exp_kl);
      chk({tag, "_exec"}, ex_cnt, exp_ex);
      chk({tag, "_l0wr"}, l0w_cnt, exp_l0w);
      chk({tag, "_ngaps"}, got_gap_q.size(), exp_nk);
      mism = 0;
      foreach (got_gap_q[i]) if (got_gap_q[i] != ROW + COL) mism++;
      chk({tag, "_drain_len_bad"}, mism, 0);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_protocol_viol"}, viol, 0);
      chk({tag, "_l0wr_lag_err"}, lag_err, 0);
   endtask

   task automatic do_run(input string tag, input int nij, input int nkij, input int w,
                         input int a, input int p, input int vm);
      bit seen;
      build_model(nij, nkij, w, a, p);
      @(negedge clk);
      #1;
      clear_mon();
      vmode = vm;
      pat_idx = 0;
      bus.nij = CB'(nij); bus.n_kij = CB'(nkij);
      bus.w_base = AW'(w); bus.a_base = AW'(a); bus.p_base = AW'(p);
      bus.start = 1'b1;
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      seen = 0;
      for (int c = 0; c < 4000 && !seen; c++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk({tag, "_done_seen"}, seen, 1);
      repeat (3) @(negedge clk);
      #1;
      chk({tag, "_busy_after"}, bus.busy, 0);
      score(tag);
   endtask

   typedef struct {
      int nij; int nkij; int w; int a; int p; int vm;
      int exp_rd; int exp_wr; int exp_lastp;
   } vec_t;
   vec_t vecs[7];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.nij = '0; bus.n_kij = '0;
      bus.w_base = '0; bus.a_base = '0; bus.p_base = '0;
      clear_mon();
      #1;
      chk("reset_inst", bus.inst, IDLE_W);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      vecs[0] = '{4, 1, 'h10,  'h40,  'h80,  0, 12, 4,  'h083};
      vecs[1] = '{4, 3, 'h10,  'h40,  'h80,  0, 36, 12, 'h08B};
      vecs[2] = '{4, 1, 'h10,  'h40,  'h80,  2, 12, 4,  'h083};
      vecs[3] = '{4, 1, 'h10,  'h40,  'h7FE, 0, 12, 4,  'h001};
      vecs[4] = '{5, 0, 'h10,  'h40,  'h80,  0, 0,  0,  0};
      vecs[5] = '{0, 2, 'h10,  'h40,  'h80,  0, 0,  0,  0};
      vecs[6] = '{1, 2, 'h7FC, 'h7FF, 'h100, 1, 18, 2,  'h101};

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         do_run(tag, vecs[i].nij, vecs[i].nkij, vecs[i].w, vecs[i].a, vecs[i].p, vecs[i].vm);
         chk({tag, "_tbl_nreads"}, got_rd_q.size(), vecs[i].exp_rd);
         chk({tag, "_tbl_nwrites"}, got_wr_q.size(), vecs[i].exp_wr);
         if (got_wr_q.size() > 0 && vecs[i].exp_wr > 0)
            chk({tag, "_tbl_lastp"}, got_wr_q[got_wr_q.size()-1], vecs[i].exp_lastp);
      end

      // First WLOAD word appears one cycle after the edge that samples start
      @(negedge clk);
      vmode = 0;
      bus.nij = 8'd4; bus.n_kij = 8'd1; bus.w_base = 11'h123; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("t0_inst_idle", bus.inst, IDLE_W);
      chk("t0_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      chk("t1_first_wload", bus.inst, (IDLE_W & ~(35'd1 << 19)) | (35'h123 << 7));
      chk("t1_busy", bus.busy, 1);
      seen = 0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      chk("t_done_seen", seen, 1);
      repeat (3) @(negedge clk);

      // nij=0: done two edges after the sampling edge, no memory activity
      #1;
      clear_mon();
      bus.nij = 8'd0; bus.n_kij = 8'd1; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("nij0_done_T", bus.done, 0);
      @(posedge clk);
      #1;
      chk("nij0_done_T1", bus.done, 1);
      chk("nij0_busy_T1", bus.busy, 1);
      @(posedge clk);
      #1;
      chk("nij0_done_T2", bus.done, 0);
      chk("nij0_busy_T2", bus.busy, 0);
      repeat (3) @(negedge clk);
      chk("nij0_reads", got_rd_q.size(), 0);
      chk("nij0_writes", got_wr_q.size(), 0);
      chk("nij0_done_cnt", done_cnt, 1);

      // start held high through a run gives exactly one run
      @(negedge clk);
      #1;
      clear_mon();
      bus.nij = 8'd2; bus.n_kij = 8'd1; bus.p_base = 11'h200; bus.start = 1'b1;
      seen = 0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
      end
      bus.start = 1'b0;
      chk("hold_done_seen", seen, 1);
      repeat (40) @(negedge clk);
      chk("hold_done_cnt", done_cnt, 1);
      chk("hold_writes", got_wr_q.size(), 2);
      chk("hold_busy", bus.busy, 0);

      // Asynchronous reset in the middle of EXEC
      @(negedge clk);
      bus.nij = 8'd4; bus.n_kij = 8'd1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (bus.inst[1]) seen = 1;
      end
      chk("rst_reach_exec", seen, 1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_inst", bus.inst, IDLE_W);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_done", bus.done, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_after_busy", bus.busy, 0);
      chk("rst_after_inst", bus.inst, IDLE_W);
      do_run("post_rst", 4, 1, 'h10, 'h40, 'h80, 0);

      for (int r = 0; r < 6; r++) begin
         do_run($sformatf("rnd%0d", r), $urandom_range(1, 6), $urandom_range(1, 3),
                $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
